axi_rd_arbiter: RTL
===================

// Module: axi_rd_arbiter
// PURPOSE
//  Shares one AXI read port (AR + R channels) between NUM_REQ local read requesters.
//  Round-robin arbitration, one transaction in flight at a time.
//  Grant is held from AR issue until the R beat carrying r_last.
//  Checks returned beat count against ar_len and flags mismatches.
// PARAMETERS
//  NUM_REQ    4   number of requesters (>=2)
//  ADDR_BITS  32  address width
//  DATA_BITS  32  read data width
//  LEN_BITS   8   burst length field width (beats-1)
//  SIZE_BITS  3   burst size field width
// PORTS
//  aclk       in   1                    single clock; all logic on posedge
//  areset     in   1                    asynchronous, active-high reset
//  req_valid  in   NUM_REQ              per-requester read request
//  req_ready  out  NUM_REQ              one-hot 1-cycle accept pulse
//  req_addr   in   NUM_REQ*ADDR_BITS    packed; slice i = requester i
//  req_len    in   NUM_REQ*LEN_BITS     packed burst length
//  req_size   in   NUM_REQ*SIZE_BITS    packed burst size
//  req_burst  in   NUM_REQ*2            packed burst type
//  rsp_valid  out  NUM_REQ              one-hot; = r_valid routed to granted requester
//  rsp_ready  in   NUM_REQ              per-requester data accept
//  rsp_data   out  DATA_BITS            = r_data (shared bus)
//  rsp_last   out  1                    = r_last
//  rsp_resp   out  2                    = r_resp
//  ar_addr/ar_len/ar_size/ar_burst  out  ADDR_BITS/LEN_BITS/SIZE_BITS/2  AXI AR payload
//  ar_valid   out  1                    AXI AR valid
//  ar_ready   in   1                    AXI AR ready
//  r_data/r_resp/r_last/r_valid  in  DATA_BITS/2/1/1  AXI R channel
//  r_ready    out  1                    AXI R ready
//  grant_id   out  $clog2(NUM_REQ)      current/last granted requester
//  busy       out  1                    high in ADDR or DATA
//  len_err    out  1                    1-cycle pulse on beat-count mismatch
// BEHAVIOUR
//  Reset: state=IDLE; ar_* payload=0; ar_valid=0; req_ready=0; grant_id=0;
//    rr_ptr=NUM_REQ-1, so requester 0 has top priority; beat_cnt=0; len_err=0.
//    Combinational outputs are forced 0 outside DATA.
//  Reset mid-operation: immediate abort to reset values. No AR/R completion is attempted.
//  FSM IDLE -> ADDR -> DATA -> IDLE.
//  IDLE: if |req_valid, pick first set bit scanning rr_ptr+1 .. rr_ptr (mod NUM_REQ).
//    Next cycle:
//    - ar_* <= winner's slice
//    - ar_valid <= 1
//    - req_ready[g] <= 1 for exactly one cycle
//    - grant_id <= g
//    - beat_cnt <= 0
//    - state <= ADDR
//  Requesters hold req_valid and payload stable until req_ready.
//    req_valid deasserting early is ignored once sampled.
//  ADDR: ar_* and ar_valid stay stable until ar_valid&ar_ready.
//    On that cycle: ar_valid <= 0, state <= DATA.
//    AR is issued at most 1 cycle after request sampling; no upper bound once issued.
//  DATA (combinational passthrough, zero latency):
//    - rsp_valid = r_valid << grant_id
//    - r_ready = rsp_ready[grant_id]
//    - rsp_data/last/resp = r_data/last/resp
//    Non-granted rsp_valid bits are 0.
//  Beat handshake = r_valid & r_ready; beat_cnt increments per beat, wraps at 2^LEN_BITS.
//  Beat with r_last=1:
//    - state <= IDLE
//    - rr_ptr <= grant_id
//    - len_err pulses if beat_cnt != ar_len
//  Beat with beat_cnt == ar_len and r_last=0: len_err pulses.
//    Block stays in DATA until r_last arrives.
//  New arbitration earliest the cycle after the r_last beat; minimum 1 IDLE cycle between bursts.
//  Simultaneous requests: only one grant; losers keep req_valid and are served in round-robin order.
//  ar_len=0 (single beat): first beat must carry r_last; else len_err.
//  Wait-state behaviour on R is entirely under rsp_ready of the granted requester.
// TESTING
//  1. Single req0 addr=0x100 len=3 -> ar_valid 1 cycle after req, req_ready[0] 1 pulse,
//     4 beats to rsp_valid[0], no len_err, busy falls after 4th beat.
//  2. req0..req3 all valid continuously -> grant order 0,1,2,3,0; each waits for prior r_last.
//  3. ar_ready held low 5 cycles -> ar_* unchanged all 5 cycles; DATA entered after handshake.
//  4. rsp_ready toggling 1,0,1,0 on len=1 burst -> r_ready mirrors it; exactly 2 beats delivered.
//  5. len=1 but r_last on beat 0 -> len_err pulse, return to IDLE.
//     len=0 without r_last -> len_err pulse, stays in DATA until r_last.
//  6. areset asserted in DATA mid-burst -> all outputs to reset values next edge;
//     req1 after release granted first if req0 idle.

Source files
------------

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: round-robin sharing of one AXI read port (AR+R) among NUM_REQ requesters,
// one burst in flight, with beat-count checking against ar_len.
module axi_rd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int ADDR_BITS = 32,
  parameter int DATA_BITS = 32,
  parameter int LEN_BITS  = 8,
  parameter int SIZE_BITS = 3
) (
  input  logic                           aclk_i,
  input  logic                           areset_i,
  input  logic [NUM_REQ-1:0]             req_valid_i,
  output logic [NUM_REQ-1:0]             req_ready_o,
  input  logic [NUM_REQ*ADDR_BITS-1:0]   req_addr_i,
  input  logic [NUM_REQ*LEN_BITS-1:0]    req_len_i,
  input  logic [NUM_REQ*SIZE_BITS-1:0]   req_size_i,
  input  logic [NUM_REQ*2-1:0]           req_burst_i,
  output logic [NUM_REQ-1:0]             rsp_valid_o,
  input  logic [NUM_REQ-1:0]             rsp_ready_i,
  output logic [DATA_BITS-1:0]           rsp_data_o,
  output logic                           rsp_last_o,
  output logic [1:0]                     rsp_resp_o,
  output logic [ADDR_BITS-1:0]           ar_addr_o,
  output logic [LEN_BITS-1:0]            ar_len_o,
  output logic [SIZE_BITS-1:0]           ar_size_o,
  output logic [1:0]                     ar_burst_o,
  output logic                           ar_valid_o,
  input  logic                           ar_ready_i,
  input  logic [DATA_BITS-1:0]           r_data_i,
  input  logic [1:0]                     r_resp_i,
  input  logic                           r_last_i,
  input  logic                           r_valid_i,
  output logic                           r_ready_o,
  output logic [$clog2(NUM_REQ)-1:0]     grant_id_o,
  output logic                           busy_o,
  output logic                           len_err_o
);
  localparam int IW = $clog2(NUM_REQ);
  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
  state_t                state_q, state_d;
  logic [IW-1:0]         rr_q, rr_d, grant_q, grant_d, win;
  logic                  found;
  logic [LEN_BITS-1:0]   beat_q, beat_d;
  logic [ADDR_BITS-1:0]  ar_addr_q, ar_addr_d;
  logic [LEN_BITS-1:0]   ar_len_q, ar_len_d;
  logic [SIZE_BITS-1:0]  ar_size_q, ar_size_d;
  logic [1:0]            ar_burst_q, ar_burst_d;
  logic                  ar_valid_q, ar_valid_d;
  logic [NUM_REQ-1:0]    req_ready_q, req_ready_d;
  logic                  len_err_q, len_err_d;
  logic                  dat, beat;
  // Scan rr_q+1 .. rr_q (mod NUM_REQ); first requester found wins.
  always_comb begin
    found = 1'b0;
    win   = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      if (!found && req_valid_i[(int'(rr_q) + i) % NUM_REQ]) begin
        found = 1'b1;
        win   = IW'((int'(rr_q) + i) % NUM_REQ);
      end
    end
  end
  assign dat         = state_q == DATA;
  assign rsp_valid_o = (dat && r_valid_i) ? NUM_REQ'(1) << grant_q : '0;
  assign r_ready_o   = dat && rsp_ready_i[grant_q];
  assign rsp_data_o  = dat ? r_data_i : '0;
  assign rsp_last_o  = dat && r_last_i;
  assign rsp_resp_o  = dat ? r_resp_i : 2'b00;
  assign beat        = dat && r_valid_i && r_ready_o;
  always_comb begin
    state_d     = state_q;
    rr_d        = rr_q;
    grant_d     = grant_q;
    beat_d      = beat_q;
    ar_addr_d   = ar_addr_q;
    ar_len_d    = ar_len_q;
    ar_size_d   = ar_size_q;
    ar_burst_d  = ar_burst_q;
    ar_valid_d  = ar_valid_q;
    req_ready_d = '0;
    len_err_d   = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        ar_addr_d   = req_addr_i[int'(win)*ADDR_BITS +: ADDR_BITS];
        ar_len_d    = req_len_i[int'(win)*LEN_BITS +: LEN_BITS];
        ar_size_d   = req_size_i[int'(win)*SIZE_BITS +: SIZE_BITS];
        ar_burst_d  = req_burst_i[int'(win)*2 +: 2];
        ar_valid_d  = 1'b1;
        req_ready_d = NUM_REQ'(1) << win;
        grant_d     = win;
        beat_d      = '0;
        state_d     = ADDR;
      end
      ADDR: if (ar_ready_i) begin
        ar_valid_d = 1'b0;
        state_d    = DATA;
      end
      DATA: if (beat) begin
        beat_d    = beat_q + 1'b1;
        len_err_d = r_last_i ? beat_q != ar_len_q : beat_q == ar_len_q;
        state_d   = r_last_i ? IDLE : DATA;
        rr_d      = r_last_i ? grant_q : rr_q;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge aclk_i or posedge areset_i) begin
    if (areset_i) begin
      state_q     <= IDLE;
      rr_q        <= IW'(NUM_REQ - 1);
      grant_q     <= '0;
      beat_q      <= '0;
      ar_addr_q   <= '0;
      ar_len_q    <= '0;
      ar_size_q   <= '0;
      ar_burst_q  <= '0;
      ar_valid_q  <= 1'b0;
      req_ready_q <= '0;
      len_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_q        <= rr_d;
      grant_q     <= grant_d;
      beat_q      <= beat_d;
      ar_addr_q   <= ar_addr_d;
      ar_len_q    <= ar_len_d;
      ar_size_q   <= ar_size_d;
      ar_burst_q  <= ar_burst_d;
      ar_valid_q  <= ar_valid_d;
      req_ready_q <= req_ready_d;
      len_err_q   <= len_err_d;
    end
  end
  assign ar_addr_o   = ar_addr_q;
  assign ar_len_o    = ar_len_q;
  assign ar_size_o   = ar_size_q;
  assign ar_burst_o  = ar_burst_q;
  assign ar_valid_o  = ar_valid_q;
  assign req_ready_o = req_ready_q;
  assign grant_id_o  = grant_q;
  assign busy_o      = state_q != IDLE;
  assign len_err_o   = len_err_q;
endmodule
